// File: rtl/serial_add_pkg.sv
// Shared definitions for the nibble-serial adder: slice width and sequencer state encoding.
package serial_add_pkg;

  localparam int unsigned CHUNK_W = 4;

  // Encoding 2'd3 is never produced; the sequencer treats it as StIdle.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_t;

endpackage

// File: rtl/add4_slice.sv
// Purely combinational 4-bit ripple-carry adder slice, time-shared by serial_add_ctrl.
module add4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[4];
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Adds WIDTH-bit operands one nibble per clock through a single add4_slice,
// LSB nibble first, with valid/ready handshakes on job and result.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned CHUNKS = WIDTH / CHUNK_W;
  localparam int unsigned STEP_W = $clog2(CHUNKS);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(CHUNKS - 1);

  state_t              state_q;
  logic [WIDTH-1:0]    a_sh_q;
  logic [WIDTH-1:0]    b_sh_q;
  logic [WIDTH-1:0]    acc_q;
  logic                carry_q;
  logic [STEP_W-1:0]   step_q;

  logic [CHUNK_W-1:0]  slice_s;
  logic                slice_c;
  logic                accept;

  add4_slice u_slice (
    .a    (a_sh_q[CHUNK_W-1:0]),
    .b    (b_sh_q[CHUNK_W-1:0]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_c)
  );

  // In StDone a new job may be taken in the same cycle the result is consumed.
  always_comb begin
    start_ready = 1'b1;
    busy        = 1'b0;
    case (state_q)
      StRun: begin
        start_ready = 1'b0;
        busy        = 1'b1;
      end
      StDone: begin
        start_ready = res_ready;
        busy        = 1'b1;
      end
      default: ;
    endcase
  end

  assign accept = start_valid & start_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      step_q    <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      res_valid <= 1'b0;
    end else if (accept) begin
      state_q   <= StRun;
      a_sh_q    <= a;
      b_sh_q    <= b;
      carry_q   <= cin;
      step_q    <= '0;
      res_valid <= 1'b0;
    end else begin
      case (state_q)
        StRun: begin
          carry_q <= slice_c;
          a_sh_q  <= a_sh_q >> CHUNK_W;
          b_sh_q  <= b_sh_q >> CHUNK_W;
          acc_q   <= {slice_s, acc_q[WIDTH-1:CHUNK_W]};
          if (step_q == LAST_STEP) begin
            state_q   <= StDone;
            sum       <= {slice_s, acc_q[WIDTH-1:CHUNK_W]};
            cout      <= slice_c;
            res_valid <= 1'b1;
          end else begin
            step_q <= step_q + STEP_W'(1);
          end
        end
        StDone: begin
          if (res_ready) begin
            state_q   <= StIdle;
            res_valid <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: directed literal jobs plus randomized traffic checked
// every cycle against a timestamp-based model of the handshake and arithmetic.
module tb_serial_add_ctrl;

  localparam int WIDTH  = 16;
  localparam int CHUNKS = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_valid = 1'b0;
  logic             start_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  int errors = 0;
  int checks = 0;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .cout        (cout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a job accepted at posedge number t0 has its result visible from
  // posedge t0+CHUNKS until the cycle it is consumed.
  int          cyc = 0;
  bit          job_active = 1'b0;
  int          job_t0 = 0;
  logic [16:0] job_res = '0;
  bit          zero_out = 1'b1;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    bit ev;
    bit er;
    if (!rst_n) begin
      chk("rst_valid", 32'(res_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_result", 32'({cout, sum}), 32'd0);
      job_active = 1'b0;
      zero_out   = 1'b1;
    end else begin
      ev = job_active && (cyc >= job_t0 + CHUNKS);
      er = !job_active || (ev && res_ready);
      chk("res_valid", 32'(res_valid), 32'(ev));
      chk("busy", 32'(busy), 32'(job_active));
      chk("start_ready", 32'(start_ready), 32'(er));
      if (ev) begin
        chk("result", 32'({cout, sum}), 32'(job_res));
        zero_out = 1'b0;
      end else if (zero_out) begin
        chk("post_reset_zero", 32'({cout, sum}), 32'd0);
      end
      if (ev && res_ready) job_active = 1'b0;
      if (start_valid && er) begin
        job_active = 1'b1;
        job_t0     = cyc + 1;
        job_res    = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      end
    end
  end

  // Single job from idle with literal expectations on latency and result.
  task automatic job(input logic [15:0] ta, input logic [15:0] tb_op, input logic tc,
                     input logic [16:0] exp, input string name);
    int lat;
    @(posedge clk) #1;
    a = ta; b = tb_op; cin = tc; start_valid = 1'b1; res_ready = 1'b0;
    @(posedge clk) #1;
    start_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(posedge clk) #1;
      lat++;
      a = 16'($urandom); b = 16'($urandom);
    end
    chk({name, "_latency"}, 32'(lat), 32'd4);
    chk({name, "_result"}, 32'({cout, sum}), 32'(exp));
    res_ready = 1'b1;
    @(posedge clk) #1;
    res_ready = 1'b0;
    chk({name, "_drop_valid"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    int r1;
    int r2;
    bit prev;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("reset_start_ready", 32'(start_ready), 32'd1);
    chk("reset_sum", 32'(sum), 32'd0);

    job(16'h0001, 16'h0008, 1'b0, 17'h00009, "t1");
    job(16'hFFFF, 16'h0001, 1'b0, 17'h10000, "t2");
    job(16'h1234, 16'h0FFF, 1'b1, 17'h02234, "t3");

    // Backpressure: hold result 5 cycles while operands churn.
    @(posedge clk) #1;
    a = 16'hA5A5; b = 16'h5A5A; cin = 1'b1; start_valid = 1'b1;
    @(posedge clk) #1;
    start_valid = 1'b0;
    for (int i = 0; i < 20 && !res_valid; i++) @(posedge clk) #1;
    for (int i = 0; i < 5; i++) begin
      a = 16'($urandom); b = 16'($urandom); start_valid = 1'($urandom);
      chk("bp_result", 32'({cout, sum}), 32'h10000);
      chk("bp_start_ready", 32'(start_ready), 32'd0);
      @(posedge clk) #1;
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk) #1;
    res_ready = 1'b0;
    chk("bp_release", 32'(res_valid), 32'd0);

    // Back-to-back: second job taken in the DONE cycle.
    @(posedge clk) #1;
    start_valid = 1'b1; res_ready = 1'b1;
    r1 = -1; r2 = -1; prev = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk) #1;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      if (res_valid && !prev) begin
        if (r1 < 0) r1 = n;
        else if (r2 < 0) r2 = n;
      end
      prev = res_valid;
    end
    chk("b2b_second_latency", 32'(r2 - (r1 + 1)), 32'd4);
    start_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 res_ready = 1'b0;

    // Reset two cycles into RUN aborts the job.
    @(posedge clk) #1;
    a = 16'h7777; b = 16'h8888; start_valid = 1'b1;
    @(posedge clk) #1;
    start_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_valid", 32'(res_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("abort_start_ready", 32'(start_ready), 32'd1);
    job(16'h8000, 16'h8000, 1'b1, 17'h10001, "t6");

    // Randomized traffic, including rare resets.
    for (int n = 0; n < 800; n++) begin
      @(posedge clk) #1;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      start_valid = ($urandom_range(0, 3) != 0);
      res_ready = 1'($urandom);
      rst_n = ($urandom_range(0, 149) != 0);
    end
    @(posedge clk) #1;
    rst_n = 1'b1; start_valid = 1'b0; res_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
